// File: rtl/multi_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// multi_pwm_ctrl
//
// Multi-channel PWM controller with a user-adjustable setpoint per channel.
// A selection index picks one channel. INC/DEC pulses nudge that channel's
// setpoint up or down, saturating at 0 and DUTY_MAX. A shared period counter
// drives all channels. Each channel latches a shadow copy of its effective
// duty at the period wrap, so a setpoint change never disturbs a period that
// is already running. A blink phase marks the selected channel on SEL_MARK.
//
// Optional feature (macro MULTI_PWM_CTRL_FADE_EN):
//   defined   -- the effective duty ramps toward the setpoint, moving by 1 on
//                each qualified FADE_CE.
//   undefined -- the effective duty is the setpoint itself and FADE_CE is
//                ignored.
//
// Ports
//   CLK        in   clock; all state changes happen on the rising edge
//   CLR        in   asynchronous active-high reset
//   CE         in   global enable; every strobe below is qualified by it
//   PWM_CE     in   period counter tick
//   FADE_CE    in   fade engine tick (used only with MULTI_PWM_CTRL_FADE_EN)
//   BLINK_CE   in   blink phase toggle tick
//   INC, DEC   in   adjust the selected channel's setpoint by STEP
//   SEL_INC,
//   SEL_DEC    in   move the channel selection, wrapping modulo CH_NUM
//   SEL        out  index of the selected channel
//   DUTY_ALL   out  packed setpoints, channel 0 in the LSBs
//   PWM_OUT    out  registered PWM outputs, active level ACT_STATE
//   SEL_MARK   out  blink marker; only the selected channel's bit can be set
// -----------------------------------------------------------------------------
module multi_pwm_ctrl #(
   parameter int   CH_NUM    = 3,
   parameter int   DUTY_BITS = 8,
   parameter int   DUTY_MAX  = 255,
   parameter int   STEP      = 1,
   parameter logic ACT_STATE = 1'b1,
   localparam int  SEL_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                        CLK,
   input  logic                        CLR,
   input  logic                        CE,
   input  logic                        PWM_CE,
   input  logic                        FADE_CE,
   input  logic                        BLINK_CE,
   input  logic                        INC,
   input  logic                        DEC,
   input  logic                        SEL_INC,
   input  logic                        SEL_DEC,
   output logic [SEL_W-1:0]            SEL,
   output logic [CH_NUM*DUTY_BITS-1:0] DUTY_ALL,
   output logic [CH_NUM-1:0]           PWM_OUT,
   output logic [CH_NUM-1:0]           SEL_MARK
);

   typedef logic [DUTY_BITS-1:0] duty_t;

   localparam duty_t      DUTY_TOP = duty_t'(DUTY_MAX);
   localparam duty_t      CNT_LAST = duty_t'(DUTY_MAX - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH_NUM - 1);

   logic [SEL_W-1:0] sel;
   duty_t            sp     [CH_NUM];  // user setpoints
   duty_t            eff    [CH_NUM];  // effective duty fed to the shadows
   duty_t            shadow [CH_NUM];  // duty in force for the running period
   duty_t            cnt;              // shared period counter
   logic             cnt_wrap;
   logic             phase;            // blink phase

   // Saturating adjust helpers. The arithmetic is done in int, so STEP may
   // exceed the headroom left in a DUTY_BITS-wide value without wrapping.
   function automatic duty_t sat_inc(input duty_t d);
      int sum;
      sum = int'(d) + STEP;
      return (sum >= DUTY_MAX) ? DUTY_TOP : duty_t'(sum);
   endfunction

   function automatic duty_t sat_dec(input duty_t d);
      int diff;
      diff = int'(d) - STEP;
      return (diff <= 0) ? '0 : duty_t'(diff);
   endfunction

   // ---------------------------------------------------------------------------
   // Channel selection and setpoints
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         sel <= '0;
         // NOTE: the setpoints live in flops rather than a RAM, so they can be
         // cleared by the async reset along with everything else.
         for (int i = 0; i < CH_NUM; i++) sp[i] <= '0;
      end else if (CE) begin
         if (SEL_INC && !SEL_DEC)
            sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
         else if (SEL_DEC && !SEL_INC)
            sel <= (sel == '0) ? SEL_LAST : sel - SEL_W'(1);

         // NOTE: non-blocking assignment means 'sel' below is the value from
         // before this edge, so an INC/DEC that coincides with a selection
         // move lands on the previously selected channel.
         for (int i = 0; i < CH_NUM; i++) begin
            if (sel == SEL_W'(i)) begin
               if (INC && !DEC)
                  sp[i] <= sat_inc(sp[i]);
               else if (DEC && !INC)
                  sp[i] <= sat_dec(sp[i]);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Effective duty
   // ---------------------------------------------------------------------------
`ifdef MULTI_PWM_CTRL_FADE_EN
   // Ramp each channel by one count per qualified fade tick toward its setpoint.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < CH_NUM; i++) eff[i] <= '0;
      end else if (CE && FADE_CE) begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (eff[i] < sp[i])
               eff[i] <= eff[i] + duty_t'(1);
            else if (eff[i] > sp[i])
               eff[i] <= eff[i] - duty_t'(1);
         end
      end
   end
`else
   logic unused_fade_ce;
   assign unused_fade_ce = FADE_CE;

   always_comb begin
      for (int i = 0; i < CH_NUM; i++) eff[i] = sp[i];
   end
`endif

   // ---------------------------------------------------------------------------
   // Period counter, shadow duties, PWM outputs, blink phase
   // ---------------------------------------------------------------------------
   assign cnt_wrap = (cnt == CNT_LAST);

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         cnt     <= '0;
         phase   <= 1'b0;
         PWM_OUT <= {CH_NUM{~ACT_STATE}};
         for (int i = 0; i < CH_NUM; i++) shadow[i] <= '0;
      end else begin
         if (CE && PWM_CE) begin
            cnt <= cnt_wrap ? '0 : cnt + duty_t'(1);
            // Shadows reload only at the wrap, so the running period keeps
            // the duty it started with.
            if (cnt_wrap) begin
               for (int i = 0; i < CH_NUM; i++) shadow[i] <= eff[i];
            end
         end

         if (CE && BLINK_CE)
            phase <= ~phase;

         // Compare the registered counter and shadow: the output follows the
         // counter one clock later. cnt never reaches DUTY_MAX, so a shadow of
         // DUTY_MAX is always active and a shadow of 0 never is.
         for (int i = 0; i < CH_NUM; i++)
            PWM_OUT[i] <= (cnt < shadow[i]) ? ACT_STATE : ~ACT_STATE;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign SEL = sel;

   always_comb begin
      // NOTE: default every combinational output first so no path through
      // the loop leaves a bit unassigned and infers a latch.
      DUTY_ALL = '0;
      SEL_MARK = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         DUTY_ALL[i*DUTY_BITS +: DUTY_BITS] = sp[i];
         SEL_MARK[i] = phase && (sel == SEL_W'(i));
      end
   end

endmodule
